seven_seg_capture: RTL and testbench

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

---
 rtl/seven_seg_capture.sv | 149 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Recovers four BCD digits from a multiplexed, active-low seven-segment display bus.
// Each digit is accepted after a stable dwell; four captured digits form a frame.
module seven_seg_capture #(
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned StaleLimit   = 1048576
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Display,
    input  logic [3:0] Transistors,
    output logic [3:0] Digit3,
    output logic [3:0] Digit2,
    output logic [3:0] Digit1,
    output logic [3:0] Digit0,
    output logic       FrameValid,
    output logic [3:0] SeenMask,
    output logic       Error,
    output logic       Stale
);

    localparam int unsigned HoldW  = 8;
    localparam int unsigned StaleW = 25;
    localparam logic [HoldW-1:0]  HoldMax   = HoldW'(SettleCycles);
    localparam logic [HoldW-1:0]  HoldPreAc = HoldW'(SettleCycles - 2);
    localparam logic [StaleW-1:0] StaleMax  = StaleW'(StaleLimit);

    logic [7:0]        r_disp_m, r_disp_s, r_disp_p;
    logic [3:0]        r_tr_m, r_tr_s, r_tr_p;
    logic [1:0]        r_run;
    logic [HoldW-1:0]  r_hold;
    logic [StaleW-1:0] r_stale_cnt;
    logic [3:0][3:0]   r_digits;
    logic [3:0]        r_seen;
    logic              r_frame_valid;
    logic              r_error;
    logic              r_stale;

    logic [3:0]        w_sel;
    logic [1:0]        w_idx;
    logic              w_active;
    logic              w_same;
    logic [HoldW-1:0]  w_hold_nxt;
    logic              w_accept;
    logic [3:0]        w_dec;
    logic              w_legal;
    logic [3:0]        w_acc_mask;
    logic [StaleW-1:0] w_stale_nxt;

    // A sample is active only when exactly one anode is driven low.
    always_comb begin
        w_sel    = ~r_tr_s;
        w_idx    = 2'd0;
        w_active = 1'b0;
        case (w_sel)
            4'b0001: begin w_idx = 2'd0; w_active = 1'b1; end
            4'b0010: begin w_idx = 2'd1; w_active = 1'b1; end
            4'b0100: begin w_idx = 2'd2; w_active = 1'b1; end
            4'b1000: begin w_idx = 2'd3; w_active = 1'b1; end
            default: begin w_idx = 2'd0; w_active = 1'b0; end
        endcase
    end

    // Segment glyph decode; dp is ignored.
    always_comb begin
        w_dec   = 4'd0;
        w_legal = 1'b1;
        case (r_disp_s[6:0])
            7'h40:   w_dec = 4'd0;
            7'h79:   w_dec = 4'd1;
            7'h24:   w_dec = 4'd2;
            7'h30:   w_dec = 4'd3;
            7'h19:   w_dec = 4'd4;
            7'h12:   w_dec = 4'd5;
            7'h02:   w_dec = 4'd6;
            7'h78:   w_dec = 4'd7;
            7'h00:   w_dec = 4'd8;
            7'h10:   w_dec = 4'd9;
            default: w_legal = 1'b0;
        endcase
    end

    // Dwell tracking: one accept on the edge the hold count reaches SettleCycles-1.
    always_comb begin
        w_same     = w_active && ({r_tr_s, r_disp_s} == {r_tr_p, r_disp_p});
        w_hold_nxt = r_hold;
        if (!w_same) begin
            w_hold_nxt = '0;
        end else if (r_hold != HoldMax) begin
            w_hold_nxt = r_hold + 1'b1;
        end
        w_accept    = w_same && r_run[1] && (r_hold == HoldPreAc);
        w_acc_mask  = (w_accept && w_legal) ? w_sel : 4'd0;
        w_stale_nxt = (r_stale_cnt == StaleMax) ? r_stale_cnt : r_stale_cnt + 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_disp_m      <= '1;
            r_disp_s      <= '1;
            r_disp_p      <= '1;
            r_tr_m        <= '1;
            r_tr_s        <= '1;
            r_tr_p        <= '1;
            r_run         <= '0;
            r_hold        <= '0;
            r_stale_cnt   <= '0;
            r_digits      <= '0;
            r_seen        <= '0;
            r_frame_valid <= 1'b0;
            r_error       <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            r_disp_m <= Display;
            r_disp_s <= r_disp_m;
            r_disp_p <= r_disp_s;
            r_tr_m   <= Transistors;
            r_tr_s   <= r_tr_m;
            r_tr_p   <= r_tr_s;
            r_run    <= {r_run[0], 1'b1};
            r_hold   <= w_hold_nxt;
            r_error  <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_digits[w_idx] <= w_dec;
            end
            // A full mask closes the frame; a same-cycle accept seeds the next one.
            if (r_seen == 4'hF) begin
                r_seen        <= w_acc_mask;
                r_frame_valid <= 1'b1;
                r_stale_cnt   <= '0;
                r_stale       <= 1'b0;
            end else begin
                r_seen        <= r_seen | w_acc_mask;
                r_frame_valid <= 1'b0;
                r_stale_cnt   <= w_stale_nxt;
                r_stale       <= (w_stale_nxt == StaleMax);
            end
        end
    end

    assign Digit3     = r_digits[3];
    assign Digit2     = r_digits[2];
    assign Digit1     = r_digits[1];
    assign Digit0     = r_digits[0];
    assign SeenMask   = r_seen;
    assign FrameValid = r_frame_valid;
    assign Error      = r_error;
    assign Stale      = r_stale;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: expected digit/error/frame events are queued
// when a pattern is driven and matched, including their cycle, as the DUT emits them.
module tb_seven_seg_capture;

    localparam int SETTLE    = 4;
    localparam int STALE_LIM = 100;
    localparam int K_DIG     = 1;
    localparam int K_ERR     = 2;
    localparam int K_FRM     = 3;

    logic       Clock;
    logic       Reset;
    logic [7:0] Display;
    logic [3:0] Transistors;
    logic [3:0] Digit3, Digit2, Digit1, Digit0;
    logic       FrameValid;
    logic [3:0] SeenMask;
    logic       Error;
    logic       Stale;

    seven_seg_capture #(
        .SettleCycles(SETTLE),
        .StaleLimit  (STALE_LIM)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Display    (Display),
        .Transistors(Transistors),
        .Digit3     (Digit3),
        .Digit2     (Digit2),
        .Digit1     (Digit1),
        .Digit0     (Digit0),
        .FrameValid (FrameValid),
        .SeenMask   (SeenMask),
        .Error      (Error),
        .Stale      (Stale)
    );

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          cyc;
    } evt_t;

    evt_t        q[$];
    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [15:0] exp_vec;
    logic [15:0] prev_vec;
    logic [15:0] mon_cur;
    logic [3:0]  exp_seen;
    bit          mon_en;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int seg2bcd(input logic [6:0] s);
        case (s)
            7'h40:   return 0;
            7'h79:   return 1;
            7'h24:   return 2;
            7'h30:   return 3;
            7'h19:   return 4;
            7'h12:   return 5;
            7'h02:   return 6;
            7'h78:   return 7;
            7'h00:   return 8;
            7'h10:   return 9;
            default: return -1;
        endcase
    endfunction

    task automatic observe(input int kind, input logic [15:0] val);
        evt_t e;
        if (q.size() == 0) begin
            check("unexpected_evt", 32'(kind), 32'd0);
            return;
        end
        e = q.pop_front();
        check("evt_kind", 32'(kind), 32'(e.kind));
        check("evt_val", 32'(val), 32'(e.val));
        check("evt_cyc", 32'(cyc), 32'(e.cyc));
        if (kind == K_FRM) check("stale_clr", 32'(Stale), 32'd0);
    endtask

    always @(negedge Clock) begin
        if (mon_en) begin
            mon_cur = {Digit3, Digit2, Digit1, Digit0};
            if (mon_cur !== prev_vec) observe(K_DIG, mon_cur);
            if (Error) observe(K_ERR, 16'h0);
            if (FrameValid) observe(K_FRM, 16'h0);
            prev_vec = mon_cur;
        end
    end

    // Drive one pattern for n cycles and queue whatever it should produce.
    task automatic step(input logic [3:0] tr, input logic [7:0] disp, input int n);
        int          zeros;
        int          idx;
        int          d;
        logic [15:0] nv;
        @(negedge Clock);
        Transistors = tr;
        Display     = disp;
        zeros = 0;
        idx   = 0;
        for (int k = 0; k < 4; k++) begin
            if (!tr[k]) begin
                zeros++;
                idx = k;
            end
        end
        d = seg2bcd(disp[6:0]);
        if (zeros == 1 && n >= SETTLE) begin
            if (d < 0) begin
                q.push_back(evt_t'{K_ERR, 16'h0, cyc + SETTLE + 2});
            end else begin
                nv = exp_vec;
                nv[idx*4 +: 4] = 4'(d);
                if (nv != exp_vec) q.push_back(evt_t'{K_DIG, nv, cyc + SETTLE + 2});
                exp_vec = nv;
                exp_seen[idx] = 1'b1;
                if (exp_seen == 4'hF) begin
                    q.push_back(evt_t'{K_FRM, 16'h0, cyc + SETTLE + 3});
                    exp_seen = 4'h0;
                end
            end
        end
        repeat (n - 1) @(negedge Clock);
        check("seen", 32'(SeenMask), 32'(exp_seen));
    endtask

    task automatic do_reset(input bit toggle);
        check("q_empty_pre_rst", 32'(q.size()), 32'd0);
        @(negedge Clock);
        mon_en = 1'b0;
        Reset  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (toggle) begin
                Transistors = 4'($urandom);
                Display     = 8'($urandom);
            end
            @(negedge Clock);
            check("rst_outs", 32'({Digit3, Digit2, Digit1, Digit0, SeenMask, FrameValid, Error, Stale}),
                  32'd0);
        end
        Transistors = 4'hF;
        Display     = 8'hFF;
        Reset       = 1'b1;
        exp_vec     = 16'h0;
        exp_seen    = 4'h0;
        prev_vec    = 16'h0;
        mon_en      = 1'b1;
    endtask

    task automatic check_digits(input string tag, input logic [15:0] want);
        check(tag, 32'({Digit3, Digit2, Digit1, Digit0}), 32'(want));
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        mon_en      = 1'b0;
        Reset       = 1'b0;
        Transistors = 4'hF;
        Display     = 8'hFF;
        exp_vec     = 16'h0;
        exp_seen    = 4'h0;
        prev_vec    = 16'h0;

        // Reset with toggling inputs, then idle: nothing moves, Stale rises at cycle 100.
        do_reset(1'b1);
        repeat (STALE_LIM - 1) @(negedge Clock);
        check("stale_pre", 32'(Stale), 32'd0);
        check_digits("idle_digits", 16'h0);
        check("idle_seen", 32'(SeenMask), 32'd0);
        @(negedge Clock);
        check("stale_rise", 32'(Stale), 32'd1);

        // Single digit capture with latency checked by the event cycle.
        step(4'hE, 8'hF9, 10);
        step(4'hF, 8'hFF, 8);
        check_digits("single_digit", 16'h0001);
        check("q_empty_single", 32'(q.size()), 32'd0);

        // Reset mid-dwell and mid-frame discards everything.
        step(4'hB, 8'hB0, 2);
        do_reset(1'b0);
        check_digits("post_rst_digits", 16'h0);
        check("post_rst_seen", 32'(SeenMask), 32'd0);

        // Full frame 5,3,2,0.
        step(4'h7, 8'h92, 10);
        step(4'hB, 8'hB0, 10);
        step(4'hD, 8'hA4, 10);
        step(4'hE, 8'hC0, 10);
        step(4'hF, 8'hFF, 8);
        check_digits("frame_digits", 16'h5320);
        check("q_empty_frame", 32'(q.size()), 32'd0);

        // Illegal glyph on digit 1.
        step(4'hD, 8'hFF, 10);
        step(4'hF, 8'hFF, 8);
        check_digits("err_digits", 16'h5320);
        check("err_seen1", 32'(SeenMask[1]), 32'd0);

        // Short dwell, two anodes low, short dwell on another digit: no accepts.
        step(4'hB, 8'h92, 3);
        step(4'hC, 8'h92, 10);
        step(4'h7, 8'h40, 3);
        step(4'hF, 8'hFF, 8);
        check_digits("abort_digits", 16'h5320);
        check("q_empty_abort", 32'(q.size()), 32'd0);

        // Re-accepting a seen digit overwrites it without touching the mask.
        step(4'hE, 8'hF9, 10);
        step(4'hF, 8'hFF, 2);
        step(4'hE, 8'hA4, 10);
        step(4'hF, 8'hFF, 8);
        check_digits("overwrite_digits", 16'h5322);

        // Go stale, then complete a frame; FrameValid clears Stale.
        step(4'hF, 8'hFF, STALE_LIM);
        check("stale_set", 32'(Stale), 32'd1);
        step(4'h7, 8'h92, 10);
        step(4'hB, 8'hB0, 10);
        step(4'hD, 8'hA4, 10);
        step(4'hF, 8'hFF, 8);
        check("stale_after_frame", 32'(Stale), 32'd0);
        check_digits("final_digits", 16'h5322);
        check("q_empty_final", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
